// File: rtl/dcache_pkg.sv
// Shared types and field widths for the direct-mapped data cache.
// Line metadata layout and the block-transfer FSM encoding live here.
package dcache_pkg;

  localparam int TAG_W  = 22;
  localparam int IDX_W  = 5;
  localparam int OFF_W  = 5;
  localparam int WSEL_W = OFF_W - 2;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    READMISS,
    READMISSOK
  } state_t;

  typedef struct packed {
    logic             valid;
    logic             dirty;
    logic [TAG_W-1:0] tag;
  } line_t;

  function automatic logic [31:0] get_word(
    input logic [255:0]      blk,
    input logic [WSEL_W-1:0] w
  );
    return blk[{w, 5'b0} +: 32];
  endfunction

endpackage

// File: rtl/dcache_sram.sv
// Cache storage: metadata and data arrays, one port, async read.
// Only valid/dirty are reset; tag and data contents are don't-care.
module dcache_sram
  import dcache_pkg::*;
#(
  parameter int LINES   = 32,
  parameter int BLOCK_W = 256
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [IDX_W-1:0]   idx,
  input  logic               we,
  input  line_t              wmeta,
  input  logic [BLOCK_W-1:0] wdata,
  output line_t              rmeta,
  output logic [BLOCK_W-1:0] rdata
);

  logic [LINES-1:0]   valid_bits;
  logic [LINES-1:0]   dirty_bits;
  logic [TAG_W-1:0]   tags  [LINES];
  logic [BLOCK_W-1:0] blocks[LINES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_bits <= '0;
      dirty_bits <= '0;
    end else if (we) begin
      valid_bits[idx] <= wmeta.valid;
      dirty_bits[idx] <= wmeta.dirty;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      tags[idx]   <= wmeta.tag;
      blocks[idx] <= wdata;
    end
  end

  assign rmeta.valid = valid_bits[idx];
  assign rmeta.dirty = dirty_bits[idx];
  assign rmeta.tag   = tags[idx];
  assign rdata       = blocks[idx];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate data cache controller.
// Hits complete combinationally; misses stall while the FSM moves blocks.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int LINES   = 32,
  parameter int BLOCK_W = 256
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [31:0]        p1_addr_i,
  input  logic [31:0]        p1_data_i,
  input  logic               p1_MemRead_i,
  input  logic               p1_MemWrite_i,
  output logic [31:0]        p1_data_o,
  output logic               p1_stall_o,
  output logic [31:0]        mem_addr_o,
  output logic [BLOCK_W-1:0] mem_data_o,
  output logic               mem_enable_o,
  output logic               mem_write_o,
  input  logic [BLOCK_W-1:0] mem_data_i,
  input  logic               mem_ack_i
);

  state_t             state;
  state_t             state_next;
  logic               req;
  logic               hit;
  logic [TAG_W-1:0]   req_tag;
  logic [IDX_W-1:0]   idx;
  logic [WSEL_W-1:0]  word;
  line_t              rmeta;
  logic [BLOCK_W-1:0] rdata;
  logic               we;
  line_t              wmeta;
  logic [BLOCK_W-1:0] wdata;
  logic [BLOCK_W-1:0] merged;
  logic               unused_addr_bits;

  assign req_tag = p1_addr_i[31:10];
  assign idx     = p1_addr_i[9:5];
  assign word    = p1_addr_i[4:2];
  assign unused_addr_bits = ^p1_addr_i[1:0];

  assign req = p1_MemRead_i | p1_MemWrite_i;
  assign hit = rmeta.valid & (rmeta.tag == req_tag);

  assign p1_stall_o = req & (~hit | (state != IDLE));
  assign p1_data_o  = req ? get_word(rdata, word) : 32'h0;

  dcache_sram #(
    .LINES   (LINES),
    .BLOCK_W (BLOCK_W)
  ) u_sram (
    .clk   (clk_i),
    .rst   (rst_i),
    .idx   (idx),
    .we    (we),
    .wmeta (wmeta),
    .wdata (wdata),
    .rmeta (rmeta),
    .rdata (rdata)
  );

  always_comb begin
    merged = rdata;
    merged[{word, 5'b0} +: 32] = p1_data_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  // Memory outputs decode only the state register, so a reset
  // drops the request asynchronously.
  always_comb begin
    state_next   = state;
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = 32'h0;
    mem_data_o   = '0;
    we           = 1'b0;
    wmeta.valid  = 1'b1;
    wmeta.dirty  = 1'b1;
    wmeta.tag    = req_tag;
    wdata        = merged;
    unique case (state)
      IDLE: begin
        if (req & ~hit) begin
          if (rmeta.valid & rmeta.dirty)
            state_next = WRITEBACK;
          else
            state_next = READMISS;
        end else if (p1_MemWrite_i & hit) begin
          we = 1'b1;
        end
      end
      WRITEBACK: begin
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = {rmeta.tag, idx, 5'b0};
        mem_data_o   = rdata;
        if (mem_ack_i) state_next = READMISS;
      end
      READMISS: begin
        mem_enable_o = 1'b1;
        mem_addr_o   = {req_tag, idx, 5'b0};
        if (mem_ack_i) begin
          we          = 1'b1;
          wmeta.dirty = 1'b0;
          wdata       = mem_data_i;
          state_next  = READMISSOK;
        end
      end
      READMISSOK: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Randomised scoreboard bench for dcache_ctrl against a flat-memory model.
// Stimulus pushes expectations; a negedge monitor pops on each completion.
module tb_dcache_ctrl;

  logic         clk_i = 0;
  logic         rst_i;
  logic [31:0]  p1_addr_i;
  logic [31:0]  p1_data_i;
  logic         p1_MemRead_i;
  logic         p1_MemWrite_i;
  logic [31:0]  p1_data_o;
  logic         p1_stall_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic         mem_enable_o;
  logic         mem_write_o;
  logic [255:0] mem_data_i;
  logic         mem_ack_i;

  dcache_ctrl dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .p1_addr_i     (p1_addr_i),
    .p1_data_i     (p1_data_i),
    .p1_MemRead_i  (p1_MemRead_i),
    .p1_MemWrite_i (p1_MemWrite_i),
    .p1_data_o     (p1_data_o),
    .p1_stall_o    (p1_stall_o),
    .mem_addr_o    (mem_addr_o),
    .mem_data_o    (mem_data_o),
    .mem_enable_o  (mem_enable_o),
    .mem_write_o   (mem_write_o),
    .mem_data_i    (mem_data_i),
    .mem_ack_i     (mem_ack_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit          is_store;
    logic [31:0] data;
    bit          miss;
    bit          wb;
    logic [31:0] wb_addr;
    logic [31:0] rd_addr;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] ext_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  bit          mvalid [32];
  bit          mdirty [32];
  logic [21:0] mtag   [32];

  int          stall_cnt     = 0;
  int          enable_cycles = 0;
  bit          seen_any      = 0;
  bit          first_write   = 0;
  bit          wb_seen       = 0;
  bit          rd_seen       = 0;
  logic [31:0] wb_addr       = 0;
  logic [31:0] rd_addr       = 0;
  int          mcnt          = 0;
  int          mlat          = 1;
  bit          hold_ack      = 0;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] ext_rd(input logic [31:0] a);
    return ext_mem.exists(a) ? ext_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  task automatic chk(input string name, input logic [255:0] act,
                     input logic [255:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic clear_txn();
    stall_cnt     = 0;
    enable_cycles = 0;
    seen_any      = 0;
    first_write   = 0;
    wb_seen       = 0;
    rd_seen       = 0;
  endtask

  // External memory: acks after a random 0..3 extra cycles.
  always @(negedge clk_i) begin
    logic [255:0] blk;
    mem_ack_i = 0;
    if (rst_i) begin
      mcnt = 0;
    end else if (mem_enable_o) begin
      enable_cycles++;
      if (!seen_any) begin
        first_write = mem_write_o;
        seen_any    = 1;
      end
      if (!hold_ack && mcnt >= mlat) begin
        mem_ack_i = 1;
        mcnt      = 0;
        mlat      = $urandom_range(0, 3);
        chk("mem_addr_align", {27'h0, mem_addr_o[4:0]}, 0);
        if (mem_write_o) begin
          wb_seen = 1;
          wb_addr = mem_addr_o;
          for (int w = 0; w < 8; w++)
            blk[w*32 +: 32] = ref_rd(mem_addr_o + 32'(w * 4));
          chk("wb_block", mem_data_o, blk);
          for (int w = 0; w < 8; w++)
            ext_mem[mem_addr_o + 32'(w * 4)] = mem_data_o[w*32 +: 32];
        end else begin
          rd_seen = 1;
          rd_addr = mem_addr_o;
          for (int w = 0; w < 8; w++)
            blk[w*32 +: 32] = ext_rd(mem_addr_o + 32'(w * 4));
          mem_data_i = blk;
        end
      end else begin
        mcnt++;
      end
    end
  end

  // Monitor: a request with stall low completes at the next edge.
  always @(negedge clk_i) begin
    exp_t e;
    if (!rst_i && (p1_MemRead_i || p1_MemWrite_i)) begin
      if (p1_stall_o) begin
        stall_cnt++;
      end else if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL sb_empty: completion with no expected entry");
      end else begin
        e = sb.pop_front();
        if (!e.is_store) chk("load_data", p1_data_o, e.data);
        chk("miss", stall_cnt != 0, e.miss);
        chk("rd_seen", rd_seen, e.miss);
        chk("wb_seen", wb_seen, e.wb);
        if (e.miss) begin
          chk("stall_cycles", stall_cnt, enable_cycles + 2);
          chk("rd_addr", rd_addr, e.rd_addr);
          chk("first_mem_write", first_write, e.wb);
        end
        if (e.wb) chk("wb_addr", wb_addr, e.wb_addr);
        clear_txn();
      end
    end
  end

  task automatic do_req(input logic [31:0] a, input bit rd, input bit wr,
                        input logic [31:0] d);
    exp_t        e;
    int          ix;
    logic [21:0] tg;
    int          n;
    ix = int'(a[9:5]);
    tg = a[31:10];
    e.is_store = wr;
    e.data     = ref_rd(a);
    e.miss     = !(mvalid[ix] && mtag[ix] == tg);
    e.wb       = e.miss && mvalid[ix] && mdirty[ix];
    e.wb_addr  = {mtag[ix], a[9:5], 5'b0};
    e.rd_addr  = {a[31:5], 5'b0};
    sb.push_back(e);
    if (e.miss) begin
      mvalid[ix] = 1;
      mtag[ix]   = tg;
      mdirty[ix] = 0;
    end
    if (wr) begin
      mdirty[ix] = 1;
      ref_mem[a] = d;
    end
    p1_addr_i     = a;
    p1_data_i     = d;
    p1_MemRead_i  = rd;
    p1_MemWrite_i = wr;
    n = 0;
    forever begin
      @(negedge clk_i);
      if (!p1_stall_o) break;
      n++;
      if (n > 200) begin
        n_checks++;
        $display("FAIL timeout: addr %0h still stalled after %0d cycles", a, n);
        break;
      end
    end
    @(posedge clk_i);
    #1;
    p1_MemRead_i  = 0;
    p1_MemWrite_i = 0;
  endtask

  logic [21:0] tags [4];
  logic [4:0]  idxs [4];

  initial begin
    logic [31:0] a;
    int          n;
    tags[0] = 22'h000001; tags[1] = 22'h000002;
    tags[2] = 22'h040000; tags[3] = 22'h3FFFFF;
    idxs[0] = 5'd0; idxs[1] = 5'd1; idxs[2] = 5'd2; idxs[3] = 5'd31;
    for (int i = 0; i < 32; i++) begin
      mvalid[i] = 0; mdirty[i] = 0; mtag[i] = 0;
    end
    ext_mem[32'h400] = 32'h1111_1111;
    ref_mem[32'h400] = 32'h1111_1111;
    rst_i = 1; p1_addr_i = 0; p1_data_i = 0;
    p1_MemRead_i = 0; p1_MemWrite_i = 0;
    mem_data_i = 0; mem_ack_i = 0;
    repeat (2) @(negedge clk_i);
    chk("rst_stall", p1_stall_o, 0);
    chk("rst_data", p1_data_o, 0);
    chk("rst_mem_enable", mem_enable_o, 0);
    chk("rst_mem_write", mem_write_o, 0);
    chk("rst_mem_addr", mem_addr_o, 0);
    chk("rst_mem_data", mem_data_o, 0);
    rst_i = 0;
    @(posedge clk_i); #1;

    do_req(32'h0000_0400, 1, 0, 0);
    do_req(32'h0000_0404, 0, 1, 32'hDEAD_BEEF);
    do_req(32'h0000_0404, 1, 0, 0);
    do_req(32'h0000_0804, 1, 0, 0);
    do_req(32'h0000_0C00, 1, 0, 0);
    do_req(32'h1000_0010, 0, 1, 32'hCAFE_F00D);
    for (int w = 0; w < 8; w++)
      do_req(32'h1000_0000 + 32'(w * 4), 1, 0, 0);

    for (int i = 0; i < 400; i++) begin
      a = {tags[$urandom_range(0, 3)], idxs[$urandom_range(0, 3)],
           3'($urandom_range(0, 7)), 2'b00};
      case ($urandom_range(0, 5))
        0, 1, 2: do_req(a, 1, 0, $urandom);
        3, 4:    do_req(a, 0, 1, $urandom);
        default: do_req(a, 1, 1, $urandom);
      endcase
      repeat ($urandom_range(0, 2)) @(posedge clk_i);
      #1;
    end

    // Abort a refill with reset; index 3 is never touched above.
    hold_ack      = 1;
    p1_addr_i     = 32'h0000_2060;
    p1_MemRead_i  = 1;
    p1_MemWrite_i = 0;
    n = 0;
    while (!(mem_enable_o && !mem_write_o) && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    chk("reached_readmiss", mem_enable_o && !mem_write_o, 1);
    @(negedge clk_i);
    #2 rst_i = 1;
    #1;
    chk("rst_drops_enable", mem_enable_o, 0);
    chk("rst_drops_write", mem_write_o, 0);
    p1_MemRead_i = 0;
    @(negedge clk_i);
    sb.delete();
    clear_txn();
    for (int i = 0; i < 32; i++) begin
      mvalid[i] = 0; mdirty[i] = 0;
    end
    ref_mem  = ext_mem;
    hold_ack = 0;
    rst_i    = 0;
    @(posedge clk_i); #1;
    do_req(32'h0000_2060, 1, 0, 0);
    do_req(32'h0000_2064, 1, 0, 0);
    do_req(32'h0000_0404, 1, 0, 0);

    repeat (3) @(posedge clk_i);
    chk("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
